// File: rtl/change_dispenser_if.sv
// change_dispenser_if: groups the payout request, tube sensors and the
// dispenser's status/solenoid outputs into one bundle.
//   change_returning / change_due : one-cycle payout request from the vending FSM
//   tube_empty                    : [2]=hi, [1]=mid, [0]=lo empty sensors
//   eject                         : solenoid drives (same bit order), one-hot or zero
//   busy, done, shortfall_flag, shortfall_amt, overrun_err, coins_dispensed : status
// master = requester side (FSM / sensors / display), slave = the dispenser.
interface change_dispenser_if;
  logic       change_returning;
  logic [7:0] change_due;
  logic [2:0] tube_empty;
  logic [2:0] eject;
  logic       busy;
  logic       done;
  logic       shortfall_flag;
  logic [7:0] shortfall_amt;
  logic       overrun_err;
  logic [7:0] coins_dispensed;

  modport master (
    output change_returning, change_due, tube_empty,
    input  eject, busy, done, shortfall_flag, shortfall_amt, overrun_err,
           coins_dispensed
  );

  modport slave (
    input  change_returning, change_due, tube_empty,
    output eject, busy, done, shortfall_flag, shortfall_amt, overrun_err,
           coins_dispensed
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a requested amount as coins from three tubes.
// Greedy selection (largest coin that fits and whose tube is not empty),
// each coin is a PULSE_CYCLES solenoid pulse followed by GAP_CYCLES off-time.
// If no coin fits the remaining amount, the remainder is reported as a
// shortfall.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : change_dispenser_if.slave (request, tube sensors, eject, status)
module change_dispenser #(
  parameter int unsigned DENOM_HI     = 5,
  parameter int unsigned DENOM_MID    = 2,
  parameter int unsigned DENOM_LO     = 1,
  parameter int unsigned PULSE_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES   = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  change_dispenser_if.slave    bus
);

  localparam logic [7:0]  D_HI       = 8'(DENOM_HI);
  localparam logic [7:0]  D_MID      = 8'(DENOM_MID);
  localparam logic [7:0]  D_LO       = 8'(DENOM_LO);
  // Timers count down to zero, so load N-1 to get exactly N cycles.
  localparam logic [31:0] PULSE_LOAD = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, EJECT, GAP, DONE, FAULT
  } state_t;

  state_t      state;
  logic [7:0]  remaining;
  logic [31:0] timer;

  // Greedy coin choice; only consumed in SELECT, so tube_empty changes
  // during EJECT/GAP have no effect.
  logic [2:0]  pick;
  logic [7:0]  pick_val;

  always_comb begin
    pick     = 3'b000;
    pick_val = 8'd0;
    if (!bus.tube_empty[2] && remaining >= D_HI) begin
      pick     = 3'b100;
      pick_val = D_HI;
    end else if (!bus.tube_empty[1] && remaining >= D_MID) begin
      pick     = 3'b010;
      pick_val = D_MID;
    end else if (!bus.tube_empty[0] && remaining >= D_LO) begin
      pick     = 3'b001;
      pick_val = D_LO;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      remaining           <= 8'd0;
      timer               <= 32'd0;
      bus.eject           <= 3'b000;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.shortfall_flag  <= 1'b0;
      bus.shortfall_amt   <= 8'd0;
      bus.overrun_err     <= 1'b0;
      bus.coins_dispensed <= 8'd0;
    end else begin
      bus.done           <= 1'b0;
      bus.shortfall_flag <= 1'b0;
      bus.overrun_err    <= 1'b0;

      // Any request outside IDLE is dropped; the payout in flight continues.
      if (state != IDLE && bus.change_returning)
        bus.overrun_err <= 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.change_returning && bus.change_due != 8'd0) begin
            remaining         <= bus.change_due;
            bus.shortfall_amt <= 8'd0;
            bus.busy          <= 1'b1;
            state             <= SELECT;
          end
        end

        SELECT: begin
          if (remaining == 8'd0) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else if (pick == 3'b000) begin
            bus.shortfall_flag <= 1'b1;
            bus.shortfall_amt  <= remaining;
            state              <= FAULT;
          end else begin
            bus.eject           <= pick;
            remaining           <= remaining - pick_val;
            bus.coins_dispensed <= bus.coins_dispensed + 8'd1;
            timer               <= PULSE_LOAD;
            state               <= EJECT;
          end
        end

        EJECT: begin
          if (timer == 32'd0) begin
            bus.eject <= 3'b000;
            timer     <= GAP_LOAD;
            state     <= GAP;
          end else begin
            timer <= timer - 32'd1;
          end
        end

        GAP: begin
          if (timer == 32'd0) state <= SELECT;
          else                timer <= timer - 32'd1;
        end

        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        FAULT: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.eject <= 3'b000;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: table-driven payouts plus hand-written
// overrun and mid-payout reset sequences.
module tb_change_dispenser;
  localparam int P   = 4;
  localparam int G   = 2;
  localparam int PER = 1 + P + G;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  change_dispenser_if bus();

  change_dispenser #(
    .DENOM_HI(5), .DENOM_MID(2), .DENOM_LO(1),
    .PULSE_CYCLES(P), .GAP_CYCLES(G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  due;
    logic [2:0]  te;
    int          n;        // coins expected
    logic [11:0] coins;    // coin k eject code at [3*k +: 3]
    bit          short_exp;
    logic [7:0]  amt;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int k, ncoin, run, gap;
    logic [2:0] prev;
    logic [2:0] got [8];
    bit fin, saw_done, saw_short;
    k = 0; ncoin = 0; run = 0; gap = 0; prev = 3'b000;
    fin = 0; saw_done = 0; saw_short = 0;
    for (int i = 0; i < 8; i++) got[i] = 3'b000;
    @(negedge clk);
    bus.change_due       = v.due;
    bus.tube_empty       = v.te;
    bus.change_returning = 1'b1;
    @(posedge clk);
    #1 bus.change_returning = 1'b0;
    while (!fin && k < 200) begin
      @(negedge clk);
      k++;
      if (prev == 3'b000 && bus.eject != 3'b000) begin
        if (ncoin < 8) got[ncoin] = bus.eject;
        if (ncoin > 0) chk($sformatf("v%0d gap_len", idx), gap, G + 1);
        ncoin++;
        run = 1;
      end else if (bus.eject != 3'b000) begin
        run++;
      end else if (prev != 3'b000) begin
        chk($sformatf("v%0d pulse_len", idx), run, P);
        gap = 1;
      end else begin
        gap++;
      end
      if (bus.done || bus.shortfall_flag) begin
        fin       = 1;
        saw_done  = bus.done;
        saw_short = bus.shortfall_flag;
      end
      prev = bus.eject;
    end
    chk($sformatf("v%0d latency", idx), k, 2 + v.n * PER);
    chk($sformatf("v%0d n_coins", idx), ncoin, v.n);
    for (int i = 0; i < v.n && i < 4; i++) begin
      logic [11:0] c;
      c = v.coins;
      chk($sformatf("v%0d coin%0d", idx, i), got[i], c[3*i +: 3]);
    end
    chk($sformatf("v%0d done", idx), saw_done, !v.short_exp);
    chk($sformatf("v%0d shortfall", idx), saw_short, v.short_exp);
    chk($sformatf("v%0d shortfall_amt", idx), bus.shortfall_amt, v.amt);
    total += v.n;
    chk($sformatf("v%0d coins_dispensed", idx), bus.coins_dispensed, total);
    @(negedge clk);
    chk($sformatf("v%0d busy_after", idx), bus.busy, 0);
    chk($sformatf("v%0d pulse_once", idx), bus.done | bus.shortfall_flag, 0);
    @(negedge clk);
    chk($sformatf("v%0d amt_held", idx), bus.shortfall_amt, v.amt);
  endtask

  vec_t vecs [6];

  initial begin
    int k, nrise, novr;
    bit seen;
    logic [2:0] prev;

    // due, tube_empty, coins, coin codes (coin0 in low bits), shortfall?, amt
    vecs[0] = '{8'd8, 3'b000, 3, {3'b000, 3'b001, 3'b010, 3'b100}, 1'b0, 8'd0};
    vecs[1] = '{8'd7, 3'b100, 4, {3'b001, 3'b010, 3'b010, 3'b010}, 1'b0, 8'd0};
    vecs[2] = '{8'd6, 3'b001, 1, {3'b000, 3'b000, 3'b000, 3'b100}, 1'b1, 8'd1};
    vecs[3] = '{8'd3, 3'b011, 0, 12'd0,                             1'b1, 8'd3};
    vecs[4] = '{8'd9, 3'b000, 3, {3'b000, 3'b010, 3'b010, 3'b100}, 1'b0, 8'd0};
    vecs[5] = '{8'd4, 3'b110, 4, {3'b001, 3'b001, 3'b001, 3'b001}, 1'b0, 8'd0};

    rst_n = 1'b0;
    bus.change_returning = 1'b0;
    bus.change_due       = 8'd0;
    bus.tube_empty       = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst eject", bus.eject, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst shortfall", bus.shortfall_flag, 0);
    chk("rst amt", bus.shortfall_amt, 0);
    chk("rst overrun", bus.overrun_err, 0);
    chk("rst coins", bus.coins_dispensed, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Overrun: second request during EJECT is dropped.
    @(negedge clk);
    bus.tube_empty = 3'b000; bus.change_due = 8'd5; bus.change_returning = 1'b1;
    @(posedge clk); #1 bus.change_returning = 1'b0;
    k = 0;
    while (bus.eject == 3'b000 && k < 50) begin @(negedge clk); k++; end
    chk("ovr eject_seen", bus.eject, 3'b100);
    bus.change_due = 8'd2; bus.change_returning = 1'b1;
    @(posedge clk); #1 bus.change_returning = 1'b0;
    @(negedge clk);
    chk("ovr pulse", bus.overrun_err, 1);
    novr = 0; nrise = 0; seen = 0; prev = bus.eject; k = 0;
    while (!seen && k < 100) begin
      @(negedge clk); k++;
      if (bus.overrun_err) novr++;
      if (prev == 3'b000 && bus.eject != 3'b000) nrise++;
      if (bus.done) seen = 1;
      prev = bus.eject;
    end
    chk("ovr single_pulse", novr, 0);
    chk("ovr extra_coins", nrise, 0);
    chk("ovr done", seen, 1);
    total += 1;
    chk("ovr coins_dispensed", bus.coins_dispensed, total);
    @(negedge clk);

    // Reset mid-EJECT abandons the payout.
    bus.change_due = 8'd8; bus.change_returning = 1'b1;
    @(posedge clk); #1 bus.change_returning = 1'b0;
    k = 0;
    while (bus.eject == 3'b000 && k < 50) begin @(negedge clk); k++; end
    chk("rmid eject_seen", bus.eject, 3'b100);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rmid eject", bus.eject, 0);
    chk("rmid busy", bus.busy, 0);
    chk("rmid coins", bus.coins_dispensed, 0);
    rst_n = 1'b1;
    total = 0;
    bus.change_due = 8'd0; bus.change_returning = 1'b1;
    @(posedge clk); #1 bus.change_returning = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.shortfall_flag || bus.eject != 3'b000) seen = 1;
    end
    chk("zero_due ignored", seen, 0);
    chk("zero_due coins", bus.coins_dispensed, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
